// File: rtl/float_mult_iter_if.sv
// Operand/result handshake bundle for the iterative float multiplier.
// The master drives operands and out_ready; the slave (multiplier) answers.
interface float_mult_iter_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  result;
   logic          invalid;
   logic          overflow;
   logic          underflow;
   logic          inexact;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, result, invalid, overflow, underflow, inexact
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, result, invalid, overflow, underflow, inexact
   );
endinterface

// File: rtl/float_mult_iter.sv
// Multi-cycle floating-point multiplier: radix-2 shift-add significand product,
// round-to-nearest-even, flush-to-zero subnormals, per-result exception flags.
module float_mult_iter #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic             clk,
   input  logic             rst,
   float_mult_iter_if.slave bus
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int P  = MAN_W + 1;          // significand width incl. hidden one
   localparam int EW = EXP_W + 2;          // signed working exponent width
   localparam int CW = $clog2(MAN_W + 2);

   localparam logic        [EW-1:0] BIAS_E   = EW'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] EXP_ZERO = '0;
   localparam logic        [W-1:0]  QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MUL, ROUND, DONE} state_t;

   state_t state_q, state_d;

   logic                 in_ready_c, out_valid_c, accept;
   logic [CW-1:0]        cnt_q;
   logic [2*P-1:0]       acc_q, mcand_q;
   logic [P-1:0]         mplier_q;
   logic                 sign_q;
   logic signed [EW-1:0] exp_q;
   logic [W-1:0]         result_q;
   logic                 invalid_q, overflow_q, underflow_q, inexact_q;

   // Operand fields and classification, evaluated on the incoming operands.
   logic                 a_sign, b_sign, in_sign;
   logic [EXP_W-1:0]     a_exp, b_exp;
   logic [MAN_W-1:0]     a_frac, b_frac;
   logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special;
   logic signed [EW-1:0] exp_in;
   logic [W-1:0]         spec_result;
   logic                 spec_invalid;

   assign {a_sign, a_exp, a_frac} = bus.a;
   assign {b_sign, b_exp, b_frac} = bus.b;
   assign in_sign = a_sign ^ b_sign;
   assign a_zero  = (a_exp == '0);
   assign b_zero  = (b_exp == '0);
   assign a_inf   = (&a_exp) & ~(|a_frac);
   assign b_inf   = (&b_exp) & ~(|b_frac);
   assign a_nan   = (&a_exp) & (|a_frac);
   assign b_nan   = (&b_exp) & (|b_frac);
   assign special = a_zero | b_zero | (&a_exp) | (&b_exp);
   assign exp_in  = EW'(a_exp) + EW'(b_exp) - BIAS_E;

   // NOTE: every combinational output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      spec_result  = {in_sign, {(W-1){1'b0}}};
      spec_invalid = 1'b0;
      if (a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf)) begin
         spec_result  = QNAN;
         spec_invalid = 1'b1;
      end else if (a_inf | b_inf) begin
         spec_result = {in_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
   end

   // Normalise, round to nearest even, then range-check the exponent.
   logic [P-1:0]         mant;
   logic [P:0]           mant_r;
   logic [MAN_W-1:0]     frac_r;
   logic                 guard, sticky, round_up;
   logic signed [EW-1:0] e_r;
   logic [W-1:0]         rnd_result;
   logic                 rnd_overflow, rnd_underflow, rnd_inexact;

   always_comb begin
      e_r = exp_q;
      if (acc_q[2*P-1]) begin
         mant   = acc_q[2*P-1 -: P];
         guard  = acc_q[P-1];
         sticky = |acc_q[P-2:0];
         e_r    = exp_q + EW'(1);
      end else begin
         mant   = acc_q[2*P-2 -: P];
         guard  = acc_q[P-2];
         sticky = |acc_q[P-3:0];
      end
      round_up = guard & (sticky | mant[0]);
      mant_r   = {1'b0, mant} + {{P{1'b0}}, round_up};
      frac_r   = mant_r[MAN_W-1:0];
      if (mant_r[P]) begin
         frac_r = mant_r[MAN_W:1];
         e_r    = e_r + EW'(1);
      end

      rnd_result    = {sign_q, e_r[EXP_W-1:0], frac_r};
      rnd_overflow  = 1'b0;
      rnd_underflow = 1'b0;
      rnd_inexact   = guard | sticky;
      if (e_r >= EXP_MAX) begin
         rnd_result   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         rnd_overflow = 1'b1;
         rnd_inexact  = 1'b1;
      end else if (e_r <= EXP_ZERO) begin
         rnd_result    = {sign_q, {(W-1){1'b0}}};
         rnd_underflow = 1'b1;
         rnd_inexact   = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready_c = ~rst;
            if (bus.in_valid & ~rst) state_d = special ? DONE : MUL;
         end
         MUL:     if (cnt_q == CW'(MAN_W)) state_d = ROUND;
         ROUND:   state_d = DONE;
         DONE: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign accept = bus.in_valid & in_ready_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         sign_q      <= 1'b0;
         exp_q       <= '0;
         result_q    <= '0;
         invalid_q   <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         inexact_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               cnt_q    <= '0;
               acc_q    <= '0;
               mcand_q  <= {{P{1'b0}}, 1'b1, a_frac};
               mplier_q <= {1'b1, b_frac};
               sign_q   <= in_sign;
               exp_q    <= exp_in;
               if (special) begin
                  result_q    <= spec_result;
                  invalid_q   <= spec_invalid;
                  overflow_q  <= 1'b0;
                  underflow_q <= 1'b0;
                  inexact_q   <= 1'b0;
               end
            end
            MUL: begin
               // One multiplier bit per cycle, LSB first, through a single adder.
               if (mplier_q[0]) acc_q <= acc_q + mcand_q;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CW'(1);
            end
            ROUND: begin
               cnt_q       <= '0;
               result_q    <= rnd_result;
               invalid_q   <= 1'b0;
               overflow_q  <= rnd_overflow;
               underflow_q <= rnd_underflow;
               inexact_q   <= rnd_inexact;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.result    = result_q;
   assign bus.invalid   = invalid_q;
   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
   assign bus.inexact   = inexact_q;
endmodule

// File: tb/tb_float_mult_iter.sv
// Self-checking bench for float_mult_iter: directed single-precision vectors,
// backpressure, mid-operation reset and random operands against a value model.
module tb_float_mult_iter;
   localparam int EXP_W   = 8;
   localparam int MAN_W   = 23;
   localparam int W       = 1 + EXP_W + MAN_W;
   localparam int P       = MAN_W + 1;
   localparam int BIAS    = (1 << (EXP_W - 1)) - 1;
   localparam int EMAX    = (1 << EXP_W) - 1;
   localparam int LAT_N   = MAN_W + 3;
   localparam int LAT_S   = 1;
   localparam int TIMEOUT = 200;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   float_mult_iter_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

   float_mult_iter #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, got, want);
      end
   endtask

   function automatic logic [3:0] flags();
      return {bus.invalid, bus.overflow, bus.underflow, bus.inexact};
   endfunction

   // Value model: exact integer significand product, then round by comparing
   // the discarded remainder with one half ULP. Flags = {inv, ovf, unf, inx}.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic [3:0] fl,
                                 output bit special);
      bit sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
      int ea, eb, e, sh;
      longint unsigned fa, fb, p, m, rem, half;
      sign   = a[W-1] ^ b[W-1];
      ea     = int'(a[W-2 -: EXP_W]);
      eb     = int'(b[W-2 -: EXP_W]);
      fa     = 64'(a[MAN_W-1:0]);
      fb     = 64'(b[MAN_W-1:0]);
      a_zero = (ea == 0);
      b_zero = (eb == 0);
      a_inf  = (ea == EMAX) && (fa == 0);
      b_inf  = (eb == EMAX) && (fb == 0);
      a_nan  = (ea == EMAX) && (fa != 0);
      b_nan  = (eb == EMAX) && (fb != 0);
      special = a_zero || b_zero || (ea == EMAX) || (eb == EMAX);
      r  = '0;
      fl = 4'b0000;
      if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
         r[W-2 -: EXP_W] = '1;
         r[MAN_W-1]      = 1'b1;
         fl              = 4'b1000;
         return;
      end
      r[W-1] = sign;
      if (a_inf || b_inf) begin
         r[W-2 -: EXP_W] = '1;
         return;
      end
      if (a_zero || b_zero) return;

      p = ((64'd1 << MAN_W) | fa) * ((64'd1 << MAN_W) | fb);
      e = ea + eb - BIAS;
      if (p >= (64'd1 << (2*P - 1))) begin
         sh = P;
         e  = e + 1;
      end else begin
         sh = P - 1;
      end
      m    = p >> sh;
      rem  = p - (m << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && m[0])) m = m + 1;
      if (m == (64'd1 << P)) begin
         m = m >> 1;
         e = e + 1;
      end
      if (e >= EMAX) begin
         r[W-2 -: EXP_W] = '1;
         fl              = 4'b0101;
      end else if (e <= 0) begin
         fl = 4'b0011;
      end else begin
         r[W-2 -: EXP_W] = EXP_W'(e);
         r[MAN_W-1:0]    = m[MAN_W-1:0];
         fl              = {3'b000, rem != 0};
      end
   endfunction

   // One full transaction with out_ready high: accept, latency, result, release.
   task automatic run_op(input string tag, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                         input logic [W-1:0] want_r, input logic [3:0] want_fl, input int want_lat);
      int lat;
      @(negedge clk);
      check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1;
      bus.a        = op_a;
      bus.b        = op_b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < TIMEOUT) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'(want_lat));
      check({tag, "_result"}, 64'(bus.result), 64'(want_r));
      check({tag, "_flags"}, 64'(flags()), 64'(want_fl));
      @(posedge clk);
      #1;
      check({tag, "_release"}, 64'(bus.out_valid), 64'd0);
   endtask

   task automatic rand_operand(output logic [W-1:0] v);
      int sel;
      logic [EXP_W-1:0] e;
      logic [MAN_W-1:0] f;
      sel = $urandom_range(0, 11);
      f   = MAN_W'($urandom);
      case (sel)
         0:       e = '0;
         1:       e = '1;
         2:       e = EXP_W'($urandom_range(200, EMAX - 1));
         3:       e = EXP_W'($urandom_range(1, 40));
         4:       begin e = EXP_W'($urandom_range(1, EMAX - 1)); f = '1; end
         default: e = EXP_W'($urandom_range(BIAS - 30, BIAS + 30));
      endcase
      if (sel == 1 && $urandom_range(0, 1) == 0) f = '0;
      v = {1'(($urandom)), e, f};
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] ra, rb, rr;
      logic [3:0]   rf;
      bit           rs;
      bit           seen;
      int           lat;

      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b1;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready_low", 64'(bus.in_ready), 64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_result", 64'(bus.result), 64'd0);
      check("rst_flags", 64'(flags()), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_in_ready_high", 64'(bus.in_ready), 64'd1);

      // Directed vectors.
      run_op("mul3x2",    32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000, LAT_N);
      run_op("neg3x2",    32'hC0400000, 32'h40000000, 32'hC0C00000, 4'b0000, LAT_N);
      run_op("rnd_inx",   32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, LAT_N);
      run_op("exact",     32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000, LAT_N);
      run_op("tie_odd",   32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, LAT_N);
      run_op("tie_even",  32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001, LAT_N);
      run_op("carry",     32'h3F842108, 32'h3FF80000, 32'h40000000, 4'b0001, LAT_N);
      run_op("max_fin",   32'h7F000000, 32'h3F800000, 32'h7F000000, 4'b0000, LAT_N);
      run_op("min_norm",  32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000, LAT_N);
      run_op("ovf",       32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101, LAT_N);
      run_op("unf",       32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, LAT_N);
      run_op("inf_x_0",   32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, LAT_S);
      run_op("ninf_x2",   32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, LAT_S);
      run_op("nan_in",    32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, LAT_S);
      run_op("nzero_x3",  32'h80000000, 32'h40400000, 32'h80000000, 4'b0000, LAT_S);
      run_op("subn_ftz",  32'h00000001, 32'h40000000, 32'h00000000, 4'b0000, LAT_S);

      // Backpressure: result held, inputs ignored, accept resumes after handshake.
      bus.out_ready = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = 32'h40400000;
      bus.b        = 32'h40000000;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < TIMEOUT) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("bp_latency", 64'(lat), 64'(LAT_N));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.a        = 32'h3F800001;
         bus.b        = 32'h7F800000;
         check("bp_in_ready", 64'(bus.in_ready), 64'd0);
         check("bp_out_valid", 64'(bus.out_valid), 64'd1);
         check("bp_result", 64'(bus.result), 64'h40C00000);
         check("bp_flags", 64'(flags()), 64'd0);
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      check("bp_in_ready_hs", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
      check("bp_done_out_valid", 64'(bus.out_valid), 64'd0);
      check("bp_resume_in_ready", 64'(bus.in_ready), 64'd1);
      run_op("after_bp", 32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000, LAT_N);

      // Reset during the 10th MUL cycle discards the operation.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = 32'h40400000;
      bus.b        = 32'h40000000;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mrst_out_valid", 64'(bus.out_valid), 64'd0);
      check("mrst_result", 64'(bus.result), 64'd0);
      check("mrst_flags", 64'(flags()), 64'd0);
      check("mrst_in_ready_low", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mrst_in_ready_high", 64'(bus.in_ready), 64'd1);
      seen = 1'b0;
      for (int i = 0; i < MAN_W + 6; i++) begin
         @(posedge clk);
         #1;
         seen = seen | bus.out_valid;
      end
      check("mrst_discarded", 64'(seen), 64'd0);
      run_op("after_rst", 32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000, LAT_N);

      // Random operands against the model.
      for (int i = 0; i < 150; i++) begin
         rand_operand(ra);
         rand_operand(rb);
         model(ra, rb, rr, rf, rs);
         run_op($sformatf("rnd%0d_%h_%h", i, ra, rb), ra, rb, rr, rf, rs ? LAT_S : LAT_N);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
